ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the

---
 rtl/ps2_host_tx_if.sv | 39 +++
 rtl/ps2_host_tx.sv | 175 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if
//  Bundles the command handshake and the PS/2 line signals of the host transmitter.
//  master : the system side (issues commands, presents raw line levels, sees status)
//  slave  : the transmitter itself
//  Signals:
//   tx_data[7:0]       byte to send
//   tx_start           send request
//   tx_busy            transmitter occupied
//   tx_done            frame sent and acknowledged (pulse)
//   tx_error           timeout or bad ack (pulse)
//   rx_inhibit         tells the receive path to ignore the lines
//   ps2_clk_in         raw PS2_CLK level
//   ps2_data_in        raw PS2_DATA level
//   ps2_clk_drive_low  1 = pull PS2_CLK low
//   ps2_data_drive_low 1 = pull PS2_DATA low
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  logic       rx_inhibit;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_drive_low;
  logic       ps2_data_drive_low;

  modport master (
    output tx_data, tx_start, ps2_clk_in, ps2_data_in,
    input  tx_busy, tx_done, tx_error, rx_inhibit,
           ps2_clk_drive_low, ps2_data_drive_low
  );

  modport slave (
    input  tx_data, tx_start, ps2_clk_in, ps2_data_in,
    output tx_busy, tx_done, tx_error, rx_inhibit,
           ps2_clk_drive_low, ps2_data_drive_low
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//  Host-to-device PS/2 transmitter. Sends one command byte to the keyboard over the
//  open-drain PS2_CLK/PS2_DATA lines: clock inhibit, request-to-send, eight data bits
//  LSB first on device clock falling edges, odd parity, stop, ack, wait for idle bus.
//  Ports:
//   clk     system clock
//   RESET   synchronous active-high reset (acts on any clk edge, ignores clk_en)
//   clk_en  tick enable; all non-reset state advances only when high
//   bus     ps2_host_tx_if.slave (command handshake, status pulses, line in/drive)
//  Parameters:
//   INHIBIT_TICKS  ticks PS2_CLK is held low before request-to-send (>= 2)
//   TIMEOUT_TICKS  ticks allowed from clock release until the frame ends
//  Build option:
//   PS2_TX_ACK_CHECK_EN  when defined, a high ack bit turns the final tx_done into tx_error;
//                        when undefined the ack value is ignored.
module ps2_host_tx #(
  parameter int INHIBIT_TICKS = 200,
  parameter int TIMEOUT_TICKS = 30000
) (
  input  logic clk,
  input  logic RESET,
  input  logic clk_en,
  ps2_host_tx_if.slave bus
);

  localparam int INH_W = $clog2(INHIBIT_TICKS + 1);
  localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, SHIFT, PARITY, STOP, WAIT_IDLE
  } state_t;

  state_t           state;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             clk_low_q;
  logic             data_low_q;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  tout_cnt;
  logic [3:0]       bit_idx;
  logic [7:0]       shift_q;
  logic             parity_q;
`ifdef PS2_TX_ACK_CHECK_EN
  logic             ack_bad_q;
`endif

  // Line synchronizers: p0/p1 form the 2-FF synchronizer, p2 holds the level seen
  // on the previous tick so an edge between ticks is still caught.
  logic ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
  logic ps2_data_p0, ps2_data_p1;

  always_ff @(posedge clk) begin
    ps2_clk_p0  <= bus.ps2_clk_in;
    ps2_clk_p1  <= ps2_clk_p0;
    ps2_data_p0 <= bus.ps2_data_in;
    ps2_data_p1 <= ps2_data_p0;
    if (clk_en) ps2_clk_p2 <= ps2_clk_p1;
  end

  logic clk_fall;
  logic timing_state;

  assign clk_fall     = ps2_clk_p2 & ~ps2_clk_p1;
  assign timing_state = (state != IDLE) && (state != INHIBIT);

  // Frame sequencer
  always_ff @(posedge clk) begin
    if (RESET) begin
      state      <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      clk_low_q  <= 1'b0;
      data_low_q <= 1'b0;
      inh_cnt    <= '0;
      tout_cnt   <= '0;
      bit_idx    <= '0;
`ifdef PS2_TX_ACK_CHECK_EN
      ack_bad_q  <= 1'b0;
`endif
    end else if (clk_en) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (timing_state && (tout_cnt == TO_W'(TIMEOUT_TICKS - 1))) begin
        // Device stalled: let go of both lines and report.
        clk_low_q  <= 1'b0;
        data_low_q <= 1'b0;
        busy_q     <= 1'b0;
        err_q      <= 1'b1;
        state      <= IDLE;
      end else begin
        if (timing_state) tout_cnt <= tout_cnt + TO_W'(1);
        case (state)
          IDLE: begin
            if (bus.tx_start) begin
              shift_q   <= bus.tx_data;
              parity_q  <= ~^bus.tx_data;
              inh_cnt   <= '0;
              busy_q    <= 1'b1;
              clk_low_q <= 1'b1;
              state     <= INHIBIT;
            end
          end
          INHIBIT: begin
            inh_cnt <= inh_cnt + INH_W'(1);
            // Start bit goes low one tick before the clock is released so the
            // device sees data low the moment the clock comes back high.
            if (inh_cnt == INH_W'(INHIBIT_TICKS - 2)) data_low_q <= 1'b1;
            if (inh_cnt == INH_W'(INHIBIT_TICKS - 1)) begin
              clk_low_q <= 1'b0;
              tout_cnt  <= '0;
              state     <= RTS;
            end
          end
          RTS: begin
            if (clk_fall) begin
              data_low_q <= ~shift_q[0];
              shift_q    <= shift_q >> 1;
              bit_idx    <= 4'd1;
              state      <= SHIFT;
            end
          end
          SHIFT: begin
            if (clk_fall) begin
              if (bit_idx == 4'd8) begin
                data_low_q <= ~parity_q;
                state      <= PARITY;
              end else begin
                data_low_q <= ~shift_q[0];
                shift_q    <= shift_q >> 1;
                bit_idx    <= bit_idx + 4'd1;
              end
            end
          end
          PARITY: begin
            if (clk_fall) begin
              data_low_q <= 1'b0;
              state      <= STOP;
            end
          end
          STOP: begin
            if (clk_fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
              ack_bad_q <= ps2_data_p1;
`endif
              state <= WAIT_IDLE;
            end
          end
          WAIT_IDLE: begin
            if (ps2_clk_p1 && ps2_data_p1) begin
              busy_q <= 1'b0;
              state  <= IDLE;
`ifdef PS2_TX_ACK_CHECK_EN
              if (ack_bad_q) err_q  <= 1'b1;
              else           done_q <= 1'b1;
`else
              done_q <= 1'b1;
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.tx_busy            = busy_q;
  assign bus.rx_inhibit         = busy_q;
  assign bus.tx_done            = done_q;
  assign bus.tx_error           = err_q;
  assign bus.ps2_clk_drive_low  = clk_low_q;
  assign bus.ps2_data_drive_low = data_low_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
//  Bench for ps2_host_tx with a behavioural PS/2 device that clocks the frame,
//  samples on rising edges and acknowledges by pulling data low. Expected frames and
//  outcomes are queued when a command is issued and popped when the device/DUT report.
module tb_ps2_host_tx;

  localparam int INHIBIT_TICKS = 200;
  localparam int TIMEOUT_TICKS = 30000;
  localparam int HALF          = 40;

  logic clk;
  logic RESET;
  logic clk_en;
  logic fast;
  logic dev_clk;
  logic dev_data;

  ps2_host_tx_if bus();

  ps2_host_tx #(
    .INHIBIT_TICKS(INHIBIT_TICKS),
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .clk   (clk),
    .RESET (RESET),
    .clk_en(clk_en),
    .bus   (bus)
  );

  // Open-drain wired-AND of host and device
  assign bus.ps2_clk_in  = ~bus.ps2_clk_drive_low  & dev_clk;
  assign bus.ps2_data_in = ~bus.ps2_data_drive_low & dev_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [10:0] sb_frame_q[$];
  logic [1:0]  sb_out_q[$];

  int  inh_ticks  = 0;
  int  tout_ticks = 0;
  int  done_cnt   = 0;
  int  err_cnt    = 0;
  logic done_prev = 1'b0;
  logic err_prev  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    clk_en = 1'b0;
    forever begin
      @(negedge clk);
      clk_en = fast ? 1'b1 : ~clk_en;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Tick-accurate observation of line drive and status pulses
  always @(negedge clk) begin
    #1;
    if (clk_en) begin
      if (bus.ps2_clk_drive_low) inh_ticks++;
      if (bus.tx_busy && !bus.ps2_clk_drive_low) tout_ticks++;
    end
    if ((bus.tx_done && !done_prev) || (bus.tx_error && !err_prev))
      check_eq("done_err_exclusive", {31'd0, bus.tx_done & bus.tx_error}, 32'd0);
    if (bus.tx_done && !done_prev) done_cnt++;
    if (bus.tx_error && !err_prev) err_cnt++;
    done_prev = bus.tx_done;
    err_prev  = bus.tx_error;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_tx(input logic [7:0] d);
    int k;
    bus.tx_data  = d;
    bus.tx_start = 1'b1;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.tx_busy) break;
    end
    bus.tx_start = 1'b0;
    check_eq("accept_busy", {31'd0, bus.tx_busy}, 32'd1);
  endtask

  // Device side of one frame. abort_after > 0 stops right after that rising-edge sample.
  task automatic dev_frame(input bit ack_high, input int abort_after,
                           output logic [10:0] bits, output bit ok);
    int k;
    bits = '0;
    ok   = 1'b0;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!bus.ps2_clk_drive_low && bus.tx_busy && !bus.ps2_data_in) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    bits[0] = bus.ps2_data_in;
    wait_clks(HALF);
    for (int i = 1; i <= 10; i++) begin
      dev_clk = 1'b0;
      wait_clks(HALF);
      dev_clk = 1'b1;
      bits[i] = bus.ps2_data_in;
      if (i == abort_after) return;
      if (i < 10) wait_clks(HALF);
    end
    wait_clks(HALF / 2);
    dev_data = ack_high;
    wait_clks(HALF / 2);
    dev_clk = 1'b0;
    wait_clks(HALF);
    dev_clk = 1'b1;
    wait_clks(HALF / 2);
    dev_data = 1'b1;
  endtask

  task automatic wait_outcome(input int d0, input int e0, output logic [1:0] got);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if ((done_cnt != d0) || (err_cnt != e0)) break;
    end
    wait_clks(4);
    got = {(err_cnt != e0) ? 1'b1 : 1'b0, (done_cnt != d0) ? 1'b1 : 1'b0};
  endtask

  task automatic run_frame(input logic [7:0] d, input bit ack_high,
                           input bit exp_err, input bit spam);
    logic [10:0] bits, exp_bits;
    logic [1:0]  got, exp_out;
    bit          ok;
    int          d0, e0;
    sb_frame_q.push_back({1'b1, ~^d, d, 1'b0});
    sb_out_q.push_back(exp_err ? 2'b10 : 2'b01);
    d0 = done_cnt;
    e0 = err_cnt;
    inh_ticks = 0;
    start_tx(d);
    if (spam) begin
      bus.tx_data  = 8'hFF;
      bus.tx_start = 1'b1;
      wait_clks(30);
      bus.tx_start = 1'b0;
    end
    dev_frame(ack_high, 0, bits, ok);
    check_eq("device_saw_rts", {31'd0, ok}, 32'd1);
    exp_bits = sb_frame_q.pop_front();
    check_eq("frame_bits", {21'd0, bits}, {21'd0, exp_bits});
    wait_outcome(d0, e0, got);
    exp_out = sb_out_q.pop_front();
    check_eq("outcome_err_done", {30'd0, got}, {30'd0, exp_out});
    check_eq("inhibit_ticks", inh_ticks, INHIBIT_TICKS);
    check_eq("idle_busy_lines", {29'd0, bus.tx_busy, bus.ps2_clk_drive_low, bus.ps2_data_drive_low}, 32'd0);
  endtask

  initial begin
    logic [10:0] bits;
    logic [1:0]  got, exp_out;
    bit          ok;
    int          d0, e0;
    bit          ackchk;

`ifdef PS2_TX_ACK_CHECK_EN
    ackchk = 1'b1;
`else
    ackchk = 1'b0;
`endif

    fast         = 1'b0;
    dev_clk      = 1'b1;
    dev_data     = 1'b1;
    bus.tx_data  = 8'h00;
    bus.tx_start = 1'b0;
    RESET        = 1'b1;
    wait_clks(5);
    check_eq("rst_busy",     {31'd0, bus.tx_busy},            32'd0);
    check_eq("rst_inhibit",  {31'd0, bus.rx_inhibit},         32'd0);
    check_eq("rst_done_err", {30'd0, bus.tx_done, bus.tx_error}, 32'd0);
    check_eq("rst_lines",    {30'd0, bus.ps2_clk_drive_low, bus.ps2_data_drive_low}, 32'd0);
    RESET = 1'b0;
    wait_clks(10);

    // Normal frames, parity both ways
    run_frame(8'hED, 1'b0, 1'b0, 1'b0);
    run_frame(8'h01, 1'b0, 1'b0, 1'b0);
    run_frame(8'h00, 1'b0, 1'b0, 1'b0);

    // Device acks high
    run_frame(8'hA5, 1'b1, ackchk, 1'b0);

    // Requests while busy are ignored; frame carries the accepted byte
    run_frame(8'hED, 1'b0, 1'b0, 1'b1);

    // Device never clocks after request-to-send
    fast = 1'b1;
    wait_clks(4);
    sb_out_q.push_back(2'b10);
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'h55);
    tout_ticks = 0;
    for (int k = 0; k < 40000; k++) begin
      @(negedge clk);
      if ((done_cnt != d0) || (err_cnt != e0)) break;
    end
    wait_clks(4);
    got = {(err_cnt != e0) ? 1'b1 : 1'b0, (done_cnt != d0) ? 1'b1 : 1'b0};
    exp_out = sb_out_q.pop_front();
    check_eq("timeout_outcome", {30'd0, got}, {30'd0, exp_out});
    check_eq("timeout_ticks", tout_ticks, TIMEOUT_TICKS);
    check_eq("timeout_idle", {29'd0, bus.tx_busy, bus.ps2_clk_drive_low, bus.ps2_data_drive_low}, 32'd0);
    fast = 1'b0;
    wait_clks(4);

    // Reset in the middle of a frame, right after the device sampled bit3
    sb_frame_q.push_back({1'b1, ~^8'h3C, 8'h3C, 1'b0});
    start_tx(8'h3C);
    dev_frame(1'b0, 4, bits, ok);
    check_eq("rst_mid_rts", {31'd0, ok}, 32'd1);
    check_eq("rst_mid_bits", {27'd0, bits[4:0]}, {27'd0, sb_frame_q.pop_front() & 11'h01F});
    d0 = done_cnt;
    e0 = err_cnt;
    RESET = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_lines", {29'd0, bus.tx_busy, bus.ps2_clk_drive_low, bus.ps2_data_drive_low}, 32'd0);
    RESET = 1'b0;
    wait_clks(300);
    check_eq("rst_mid_no_pulse", done_cnt + err_cnt, d0 + e0);

    // Recovers for a following frame
    run_frame(8'hFF, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
